// File: rtl/ctrl_unit_if.sv
// Control bundle between the multicycle control FSM and its datapath.
// The FSM is the master: it receives IR fields and the zero flag, and drives every strobe.
interface ctrl_unit_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_write;
    logic       mdr_load;
    logic       regA_load;
    logic       regB_load;
    logic       alu_out_load;
    logic       reg_write;
    logic       mux_a_control;
    logic [1:0] mux_b_control;
    logic [2:0] alu_control;
    logic [1:0] mux_pc_control;
    logic       mux_wr_reg_control;
    logic       mux_wr_data_control;
    logic       illegal_op;
    logic [3:0] state_out;

    modport master (
        input  opcode, funct, zero,
        output pc_write, ir_write, iord, mem_write, mdr_load,
               regA_load, regB_load, alu_out_load, reg_write,
               mux_a_control, mux_b_control, alu_control,
               mux_pc_control, mux_wr_reg_control,
               mux_wr_data_control, illegal_op, state_out
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_write, ir_write, iord, mem_write, mdr_load,
               regA_load, regB_load, alu_out_load, reg_write,
               mux_a_control, mux_b_control, alu_control,
               mux_pc_control, mux_wr_reg_control,
               mux_wr_data_control, illegal_op, state_out
    );
endinterface

// File: rtl/ctrl_unit.sv
// Moore control FSM for a multicycle MIPS-subset datapath.
// Supports add/sub/and, addi, lw, sw, beq and j; flags everything else.
module ctrl_unit (
    input logic         clk,
    input logic         reset,
    ctrl_unit_if.master bus
);
    localparam logic [3:0] S_RST         = 4'd0;
    localparam logic [3:0] S_FETCH       = 4'd1;
    localparam logic [3:0] S_FETCH_WAIT  = 4'd2;
    localparam logic [3:0] S_DECODE      = 4'd3;
    localparam logic [3:0] S_EXEC_R      = 4'd4;
    localparam logic [3:0] S_WB_R        = 4'd5;
    localparam logic [3:0] S_EXEC_ADDI   = 4'd6;
    localparam logic [3:0] S_WB_I        = 4'd7;
    localparam logic [3:0] S_ADDR        = 4'd8;
    localparam logic [3:0] S_MEM_RD      = 4'd9;
    localparam logic [3:0] S_MEM_RD_WAIT = 4'd10;
    localparam logic [3:0] S_WB_LW       = 4'd11;
    localparam logic [3:0] S_MEM_WR      = 4'd12;
    localparam logic [3:0] S_BRANCH      = 4'd13;
    localparam logic [3:0] S_JUMP        = 4'd14;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;

    logic [3:0] state;
    logic [3:0] nxt;
    logic       r_ok;

    assign r_ok = (bus.funct == FN_ADD) ||
                  (bus.funct == FN_SUB) ||
                  (bus.funct == FN_AND);

    assign bus.state_out = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_RST;
        else        state <= nxt;
    end

    always_comb begin
        nxt                     = S_FETCH;
        bus.pc_write            = 1'b0;
        bus.ir_write            = 1'b0;
        bus.iord                = 1'b0;
        bus.mem_write           = 1'b0;
        bus.mdr_load            = 1'b0;
        bus.regA_load           = 1'b0;
        bus.regB_load           = 1'b0;
        bus.alu_out_load        = 1'b0;
        bus.reg_write           = 1'b0;
        bus.mux_a_control       = 1'b0;
        bus.mux_b_control       = 2'b00;
        bus.alu_control         = 3'b000;
        bus.mux_pc_control      = 2'b00;
        bus.mux_wr_reg_control  = 1'b0;
        bus.mux_wr_data_control = 1'b0;
        bus.illegal_op          = 1'b0;

        case (state)
            S_RST:   nxt = S_FETCH;
            S_FETCH: nxt = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                bus.ir_write      = 1'b1;
                bus.mux_b_control = 2'b01;
                bus.alu_control   = ALU_ADD;
                bus.pc_write      = 1'b1;
                nxt               = S_DECODE;
            end
            S_DECODE: begin
                // precompute the branch target while the opcode is decoded
                bus.regA_load     = 1'b1;
                bus.regB_load     = 1'b1;
                bus.mux_b_control = 2'b11;
                bus.alu_control   = ALU_ADD;
                bus.alu_out_load  = 1'b1;
                unique case (1'b1)
                    (bus.opcode == OP_R) && r_ok: nxt = S_EXEC_R;
                    bus.opcode == OP_ADDI:        nxt = S_EXEC_ADDI;
                    bus.opcode == OP_LW,
                    bus.opcode == OP_SW:          nxt = S_ADDR;
                    bus.opcode == OP_BEQ:         nxt = S_BRANCH;
                    bus.opcode == OP_J:           nxt = S_JUMP;
                    default: begin
                        bus.illegal_op = 1'b1;
                        nxt            = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                bus.mux_a_control = 1'b1;
                bus.alu_out_load  = 1'b1;
                unique case (1'b1)
                    bus.funct == FN_ADD: bus.alu_control = ALU_ADD;
                    bus.funct == FN_SUB: bus.alu_control = ALU_SUB;
                    bus.funct == FN_AND: bus.alu_control = ALU_AND;
                    default:             bus.alu_control = 3'b000;
                endcase
                nxt = S_WB_R;
            end
            S_WB_R: begin
                bus.reg_write          = 1'b1;
                bus.mux_wr_reg_control = 1'b1;
            end
            S_EXEC_ADDI, S_ADDR: begin
                bus.mux_a_control = 1'b1;
                bus.mux_b_control = 2'b10;
                bus.alu_control   = ALU_ADD;
                bus.alu_out_load  = 1'b1;
                if (state == S_EXEC_ADDI)      nxt = S_WB_I;
                else if (bus.opcode == OP_LW)  nxt = S_MEM_RD;
                else                           nxt = S_MEM_WR;
            end
            S_WB_I: bus.reg_write = 1'b1;
            S_MEM_RD: begin
                bus.iord = 1'b1;
                nxt      = S_MEM_RD_WAIT;
            end
            S_MEM_RD_WAIT: begin
                bus.mdr_load = 1'b1;
                nxt          = S_WB_LW;
            end
            S_WB_LW: begin
                bus.reg_write           = 1'b1;
                bus.mux_wr_data_control = 1'b1;
            end
            S_MEM_WR: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_BRANCH: begin
                bus.mux_a_control  = 1'b1;
                bus.alu_control    = ALU_SUB;
                bus.mux_pc_control = 2'b01;
                bus.pc_write       = bus.zero;
            end
            S_JUMP: begin
                bus.mux_pc_control = 2'b10;
                bus.pc_write       = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
    end
endmodule

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 The module SHALL have these ports, one clock domain: clk in 1 system clock, rising edge; reset in 1 asynchronous active-low reset; opcode in 6 IR[31:26]; funct in 6 IR[5:0]; zero in 1 ALU zero flag.
REQ-002 The module SHALL have these outputs: pc_write 1; ir_write 1; iord 1 (0=PC, 1=ALUOut address); mem_write 1; mdr_load 1; regA_load 1; regB_load 1; alu_out_load 1; reg_write 1; mux_a_control 1 (0=PC, 1=regA); mux_b_control 2 (00 regB, 01 const 4, 10 sign-extend16_32, 11 shift-left-2); alu_control 3 (001 add, 010 sub, 011 and); mux_pc_control 2 (00 ALU result, 01 ALUOut, 10 jump target); mux_wr_reg_control 1 (0=rt, 1=rd); mux_wr_data_control 1 (0=ALUOut, 1=MDR); illegal_op 1; state_out 4.

Function
REQ-003 The unit SHALL be a Moore FSM with a 4-bit state register; all outputs except pc_write in BRANCH and illegal_op SHALL decode from state only; unlisted outputs in any state SHALL be 0.
REQ-004 State codes SHALL be: RST=0, FETCH=1, FETCH_WAIT=2, DECODE=3, EXEC_R=4, WB_R=5, EXEC_ADDI=6, WB_I=7, ADDR=8, MEM_RD=9, MEM_RD_WAIT=10, WB_LW=11, MEM_WR=12, BRANCH=13, JUMP=14; state_out SHALL equal the state register.
REQ-005 The RST state SHALL drive all outputs to 0 and SHALL go to FETCH on the next edge.
REQ-006 FETCH SHALL drive iord=0 and SHALL go to FETCH_WAIT.
REQ-007 FETCH_WAIT SHALL drive ir_write=1, mux_a=0, mux_b=01, alu=001, mux_pc=00, pc_write=1 (PC<=PC+4), and SHALL go to DECODE.
REQ-008 DECODE SHALL drive regA_load=1, regB_load=1, mux_a=0, mux_b=11, alu=001, alu_out_load=1 (branch target).
REQ-009 DECODE SHALL dispatch on opcode: 0x00 to EXEC_R; 0x08 to EXEC_ADDI; 0x23 and 0x2B to ADDR; 0x04 to BRANCH; 0x02 to JUMP.
REQ-010 In DECODE, any other opcode, or opcode 0x00 with funct not in {0x20,0x22,0x24}, SHALL assert illegal_op=1 for that cycle and SHALL go to FETCH.
REQ-011 EXEC_R SHALL drive mux_a=1, mux_b=00, alu_out_load=1, and alu_control 001/010/011 for funct 0x20/0x22/0x24; it SHALL go to WB_R.
REQ-012 WB_R SHALL drive reg_write=1, mux_wr_reg=1, mux_wr_data=0, and SHALL go to FETCH.
REQ-013 EXEC_ADDI SHALL drive mux_a=1, mux_b=10, alu=001, alu_out_load=1, and SHALL go to WB_I; WB_I SHALL drive reg_write=1, mux_wr_reg=0, mux_wr_data=0, and SHALL go to FETCH.
REQ-014 ADDR SHALL drive mux_a=1, mux_b=10, alu=001, alu_out_load=1, and SHALL go to MEM_RD if opcode=0x23, else to MEM_WR.
REQ-015 MEM_RD SHALL drive iord=1 and SHALL go to MEM_RD_WAIT; MEM_RD_WAIT SHALL drive mdr_load=1 and SHALL go to WB_LW.
REQ-016 WB_LW SHALL drive reg_write=1, mux_wr_reg=0, mux_wr_data=1, and SHALL go to FETCH.
REQ-017 MEM_WR SHALL drive iord=1, mem_write=1, and SHALL go to FETCH.
REQ-018 BRANCH SHALL drive mux_a=1, mux_b=00, alu=010, mux_pc=01, pc_write=zero (combinational on same cycle), and SHALL go to FETCH.
REQ-019 JUMP SHALL drive mux_pc=10, pc_write=1, and SHALL go to FETCH.
REQ-020 Instruction latency in cycles, FETCH through last state inclusive, SHALL be: R-type 5, addi 5, lw 7, sw 5, beq 4, j 4, illegal 3.
REQ-021 No two of pc_write, mem_write, reg_write, or ir_write SHALL be 1 in the same state, except pc_write with ir_write in FETCH_WAIT.

Reset
REQ-022 When reset=0, the state SHALL become RST immediately, independent of clk, and all outputs SHALL be 0, including mid-instruction (e.g. during MEM_WR, mem_write SHALL drop without waiting for an edge).
REQ-023 After reset rises, the first rising edge SHALL move RST to FETCH.

Verification
REQ-024 Release reset, opcode=0x00, funct=0x20 -> states 0,1,2,3,4,5,1; reg_write=1 only in state 5 with mux_wr_reg=1.
REQ-025 Opcode=0x23 -> states 1,2,3,8,9,10,11,1; mdr_load=1 only in state 10; iord=1 only in state 9.
REQ-026 Opcode=0x04 with zero=1, then repeat with zero=0 -> in state 13, pc_write=1 then pc_write=0; mux_pc=01 in both cases.
REQ-027 Opcode=0x3F, then opcode=0x00 with funct=0x25 -> illegal_op=1 for one cycle in state 3 in each case, next state 1, no reg_write or mem_write asserted.
REQ-028 Opcode=0x2B, assert reset=0 mid-cycle in state 12 -> mem_write falls to 0 asynchronously, state_out=0; on release, FETCH follows after one edge.
REQ-029 Opcode=0x02 -> states 1,2,3,14,1; pc_write=1 in states 2 and 14 only, with mux_pc=10 in state 14.
